// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the word-serial wide adder.
package wide_add_sequencer_pkg;

   localparam int WORD_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle: master is the producer/consumer, slave the sequencer.
interface wide_add_sequencer_if #(
   parameter int WORDS = 4
);
   import wide_add_sequencer_pkg::*;

   localparam int W = WORDS * WORD_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         busy;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );

endinterface

// File: rtl/wide_add_sequencer_adder.sv
// 10-bit carry-select adder with growing group sizes (3/3/4) so the select chain stays short.
module square_root_adder
   import wide_add_sequencer_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              c_in,
   output logic [WORD_W-1:0] s,
   output logic              c_out
);

   logic [3:0] g0;
   logic [3:0] g1_c0, g1_c1;
   logic [4:0] g2_c0, g2_c1;
   logic       c1, c2;

   assign g0    = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c_in};
   // Upper groups are computed for both carry-in values and picked afterwards.
   assign g1_c0 = {1'b0, a[5:3]} + {1'b0, b[5:3]};
   assign g1_c1 = {1'b0, a[5:3]} + {1'b0, b[5:3]} + 4'd1;
   assign g2_c0 = {1'b0, a[9:6]} + {1'b0, b[9:6]};
   assign g2_c1 = {1'b0, a[9:6]} + {1'b0, b[9:6]} + 5'd1;

   assign c1 = g0[3];
   assign c2 = c1 ? g1_c1[3] : g1_c0[3];

   assign s[2:0] = g0[2:0];
   assign s[5:3] = c1 ? g1_c1[2:0] : g1_c0[2:0];
   assign s[9:6] = c2 ? g2_c1[3:0] : g2_c0[3:0];
   assign c_out  = c2 ? g2_c1[4]   : g2_c0[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial WORDS*10-bit add/subtract: one 10-bit adder reused LS word first,
// carry chained through a register between cycles.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   wide_add_sequencer_if.slave       bus
);

   localparam int W  = WORDS * WORD_W;
   localparam int IW = $clog2(WORDS);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic [IW-1:0]      idx_q, idx_d;

   logic [WORD_W-1:0]  a_word [WORDS];
   logic [WORD_W-1:0]  b_word [WORDS];
   logic [WORD_W-1:0]  add_a, add_b, add_s;
   logic               add_co;
   logic               last_word;

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign a_word[gi] = a_q[gi*WORD_W +: WORD_W];
         assign b_word[gi] = b_q[gi*WORD_W +: WORD_W];
      end
   endgenerate

   assign add_a     = a_word[idx_q];
   assign add_b     = b_word[idx_q];
   assign last_word = (idx_q == IW'(WORDS - 1));

   square_root_adder u_adder (
      .a     (add_a),
      .b     (add_b),
      .c_in  (carry_q),
      .s     (add_s),
      .c_out (add_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
               a_d     = bus.in_a;
               b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
               carry_d = bus.in_sub;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[idx_q*WORD_W +: WORD_W] = add_s;
            carry_d = add_co;
            if (last_word) begin
               cout_d  = add_co;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[WORD_W-1] != a_q[W-1]);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;

endmodule
